// File: rtl/fifo_frame_tx.sv
// fifo_frame_tx: drains 16-bit FIFO words into sync/seq/data byte frames on a valid/ready stream.
// Define FRAME_CHECKSUM_EN to append a mod-256 checksum of the seq and data bytes to each frame.
module fifo_frame_tx #(
    parameter int         DATA_WIDTH    = 16,
    parameter int         FRAME_SAMPLES = 8,
    parameter logic [7:0] SYNC_BYTE     = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_a,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  frame_busy,
    output logic                  frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        SEQ,
        RD_REQ,
        RD_WAIT,
        DATA_HI,
        DATA_LO
`ifdef FRAME_CHECKSUM_EN
        , CSUM
`endif
    } state_t;

    localparam logic [8:0] LastCount = 9'(FRAME_SAMPLES);

    state_t                  state_q, state_d;
    logic [7:0]              seq_q, seq_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   sample_q, sample_d;
    logic                    done_q, done_d;
    logic [8:0]              cntInc;
    logic                    endFrame;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]              csum_q, csum_d;
`endif

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state_q  <= IDLE;
            seq_q    <= 8'h00;
            cnt_q    <= 8'h00;
            sample_q <= '0;
            done_q   <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            csum_q   <= 8'h00;
`endif
        end else begin
            state_q  <= state_d;
            seq_q    <= seq_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            done_q   <= done_d;
`ifdef FRAME_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    assign cntInc = {1'b0, cnt_q} + 9'd1;

    // Byte-presenting states hold tx_data from registers only, so it stays stable under backpressure.
    always_comb begin
        state_d    = state_q;
        seq_d      = seq_q;
        cnt_d      = cnt_q;
        sample_d   = sample_q;
        done_d     = 1'b0;
        endFrame   = 1'b0;
        fifo_rd_en = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
`ifdef FRAME_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = SYNC;
            end
            SYNC: begin
                tx_valid = 1'b1;
                tx_data  = SYNC_BYTE;
                if (tx_ready) begin
                    state_d = SEQ;
`ifdef FRAME_CHECKSUM_EN
                    csum_d  = 8'h00;
`endif
                end
            end
            SEQ: begin
                tx_valid = 1'b1;
                tx_data  = seq_q;
                if (tx_ready) begin
                    state_d = RD_REQ;
`ifdef FRAME_CHECKSUM_EN
                    csum_d  = csum_q + seq_q;
`endif
                end
            end
            RD_REQ: begin
                if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    state_d    = RD_WAIT;
                end
            end
            RD_WAIT: begin
                sample_d = fifo_dout;
                state_d  = DATA_HI;
            end
            DATA_HI: begin
                tx_valid = 1'b1;
                tx_data  = sample_q[DATA_WIDTH-1 -: 8];
                if (tx_ready) begin
                    state_d = DATA_LO;
`ifdef FRAME_CHECKSUM_EN
                    csum_d  = csum_q + sample_q[DATA_WIDTH-1 -: 8];
`endif
                end
            end
            DATA_LO: begin
                tx_valid = 1'b1;
                tx_data  = sample_q[7:0];
                if (tx_ready) begin
`ifdef FRAME_CHECKSUM_EN
                    csum_d = csum_q + sample_q[7:0];
`endif
                    if (cntInc < LastCount) begin
                        cnt_d   = cntInc[7:0];
                        state_d = RD_REQ;
                    end else begin
`ifdef FRAME_CHECKSUM_EN
                        cnt_d   = 8'h00;
                        state_d = CSUM;
`else
                        endFrame = 1'b1;
`endif
                    end
                end
            end
`ifdef FRAME_CHECKSUM_EN
            CSUM: begin
                tx_valid = 1'b1;
                tx_data  = csum_q;
                if (tx_ready) endFrame = 1'b1;
            end
`endif
            default: state_d = IDLE;
        endcase

        if (endFrame) begin
            seq_d   = seq_q + 8'd1;
            cnt_d   = 8'h00;
            done_d  = 1'b1;
            state_d = IDLE;
        end
    end

    assign frame_busy = (state_q != IDLE);
    assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_frame_tx.sv
// tb_fifo_frame_tx: drives fifo_frame_tx from a modelled FIFO and checks the byte stream against
// frames built directly from the framing rules (sync, seq, MSB-first samples, optional checksum).
module tb_fifo_frame_tx;

    localparam int NS = 2;
`ifdef FRAME_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    localparam int FL = 2 + 2 * NS + CS;

    logic        clk = 1'b0;
    logic        rst_a = 1'b1;
    logic        fifo_empty = 1'b1;
    logic [15:0] fifo_dout = 16'h0000;
    logic        fifo_rd_en;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        frame_busy;
    logic        frame_done;

    fifo_frame_tx #(
        .DATA_WIDTH   (16),
        .FRAME_SAMPLES(NS),
        .SYNC_BYTE    (8'hA5)
    ) dut (
        .clk       (clk),
        .rst_a     (rst_a),
        .fifo_empty(fifo_empty),
        .fifo_dout (fifo_dout),
        .fifo_rd_en(fifo_rd_en),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .frame_busy(frame_busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int          compared = 0;
    int          mismatched = 0;
    logic [15:0] fifoQ[$];
    logic [7:0]  rxBytes[$];
    logic [7:0]  expQ[$];
    bit          popPending = 0;
    int          readyMode = 0;
    int          rdCount = 0;
    int          doneCount = 0;
    int          busyCnt = 0;
    int          cycleCnt = 0;
    int          lastAccCycle = 0;
    bit          prevStall = 0;
    logic [7:0]  prevData = 8'h00;
    logic [7:0]  modelSeq = 8'h00;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock of stimulus: complete a pending FIFO pop and set tx_ready, just after the edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        if (popPending) begin
            if (fifoQ.size() > 0) fifo_dout = fifoQ.pop_front();
            popPending = 0;
        end
        case (readyMode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = 1'($urandom_range(0, 1));
            default: tx_ready = 1'b0;
        endcase
        fifo_empty = (fifoQ.size() == 0);
    endtask

    task automatic pushFrame(input logic [15:0] words [NS]);
        int sum;
        sum = int'(modelSeq);
        expQ.push_back(8'hA5);
        expQ.push_back(modelSeq);
        foreach (words[i]) begin
            fifoQ.push_back(words[i]);
            expQ.push_back(words[i][15:8]);
            expQ.push_back(words[i][7:0]);
            sum = (sum + int'(words[i][15:8]) + int'(words[i][7:0])) % 256;
        end
`ifdef FRAME_CHECKSUM_EN
        expQ.push_back(8'(sum));
`endif
        modelSeq = modelSeq + 8'd1;
        fifo_empty = (fifoQ.size() == 0);
    endtask

    task automatic addFrames(input int n);
        logic [15:0] w [NS];
        for (int f = 0; f < n; f++) begin
            foreach (w[i]) w[i] = 16'($urandom);
            pushFrame(w);
        end
    endtask

    task automatic runUntilDone(input int target, input int budget, input string tag);
        int n = 0;
        while (doneCount < target && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput(tag, 32'(doneCount), 32'(target));
    endtask

    task automatic compareStream(input string tag);
        checkOutput({tag, "_len"}, 32'(rxBytes.size()), 32'(expQ.size()));
        for (int i = 0; i < rxBytes.size() && i < expQ.size(); i++)
            checkOutput($sformatf("%s_byte%0d", tag, i), 32'(rxBytes[i]), 32'(expQ[i]));
        rxBytes.delete();
        expQ.delete();
    endtask

    function automatic logic [7:0] byteAt(input int i);
        if (i < rxBytes.size()) return rxBytes[i];
        return 8'hxx;
    endfunction

    // Passive monitor on the falling edge: records accepted bytes, reads and frame_done timing.
    always @(negedge clk) begin
        if (rst_a) begin
            prevStall = 0;
        end else begin
            cycleCnt++;
            if (frame_busy) busyCnt++;
            if (fifo_rd_en) begin
                checkOutput("rd_when_empty", 32'(fifo_empty), 32'(0));
                rdCount++;
                popPending = 1;
            end
            if (prevStall) begin
                checkOutput("hold_valid", 32'(tx_valid), 32'(1));
                checkOutput("hold_data", 32'(tx_data), 32'(prevData));
            end
            if (tx_valid && tx_ready) begin
                rxBytes.push_back(tx_data);
                lastAccCycle = cycleCnt;
            end
            if (frame_done) begin
                doneCount++;
                checkOutput("done_gap", 32'(cycleCnt - lastAccCycle), 32'(1));
            end
            prevStall = tx_valid && !tx_ready;
            prevData  = tx_data;
        end
    end

    initial begin
        logic [15:0] dw [NS];
        logic [15:0] heldWord;
        int d0, rd0, doneBefore, n;

        // Reset values
        applyStimulus();
        applyStimulus();
        checkOutput("rst_rd_en", 32'(fifo_rd_en), 32'(0));
        checkOutput("rst_valid", 32'(tx_valid), 32'(0));
        checkOutput("rst_data", 32'(tx_data), 32'(0));
        checkOutput("rst_busy", 32'(frame_busy), 32'(0));
        checkOutput("rst_done", 32'(frame_done), 32'(0));
        rst_a = 1'b0;
        applyStimulus();

        // Directed frame 0x1234, 0xABCD with tx_ready high
        readyMode = 0;
        busyCnt = 0;
        rd0 = rdCount;
        dw = '{16'h1234, 16'hABCD};
        pushFrame(dw);
        runUntilDone(1, 100, "dir_done");
        checkOutput("dir_reads", 32'(rdCount - rd0), 32'(NS));
        checkOutput("dir_busy_len", 32'(busyCnt), 32'(2 + 4 * NS + CS));
        checkOutput("dir_sync", 32'(byteAt(0)), 32'h0A5);
        checkOutput("dir_seq", 32'(byteAt(1)), 32'h000);
        checkOutput("dir_hi0", 32'(byteAt(2)), 32'h012);
        checkOutput("dir_lo1", 32'(byteAt(5)), 32'h0CD);
`ifdef FRAME_CHECKSUM_EN
        checkOutput("dir_csum", 32'(byteAt(6)), 32'h0BE);
`endif
        compareStream("dir");

        // Random backpressure over 4 frames
        readyMode = 1;
        d0 = doneCount;
        addFrames(4);
        runUntilDone(d0 + 4, 400, "rnd_done");
        compareStream("rnd");

        // FIFO runs dry after the first sample of a frame
        readyMode = 0;
        d0 = doneCount;
        rd0 = rdCount;
        addFrames(1);
        heldWord = fifoQ.pop_back();
        fifo_empty = (fifoQ.size() == 0);
        for (int i = 0; i < 30; i++) applyStimulus();
        checkOutput("stall_reads", 32'(rdCount - rd0), 32'(1));
        checkOutput("stall_busy", 32'(frame_busy), 32'(1));
        checkOutput("stall_rd_en", 32'(fifo_rd_en), 32'(0));
        checkOutput("stall_bytes", 32'(rxBytes.size()), 32'(4));
        checkOutput("stall_no_done", 32'(doneCount), 32'(d0));
        fifoQ.push_back(heldWord);
        fifo_empty = 1'b0;
        runUntilDone(d0 + 1, 100, "stall_done");
        compareStream("stall");

        // Reset while frame 3 is presenting its first DATA_LO byte
        d0 = doneCount;
        addFrames(3);
        n = 0;
        while (rxBytes.size() < 2 * FL + 3 && n < 200) begin
            applyStimulus();
            n++;
        end
        readyMode = 2;
        tx_ready = 1'b0;
        checkOutput("lo_reach", 32'(rxBytes.size()), 32'(2 * FL + 3));
        #1;
        checkOutput("lo_valid", 32'(tx_valid), 32'(1));
        checkOutput("lo_data", 32'(tx_data), 32'(expQ[2 * FL + 3]));
        doneBefore = doneCount;
        checkOutput("pre_rst_done", 32'(doneBefore - d0), 32'(2));
        rst_a = 1'b1;
        #1;
        checkOutput("mid_rst_valid", 32'(tx_valid), 32'(0));
        checkOutput("mid_rst_busy", 32'(frame_busy), 32'(0));
        checkOutput("mid_rst_data", 32'(tx_data), 32'(0));
        checkOutput("mid_rst_rd_en", 32'(fifo_rd_en), 32'(0));
        while (expQ.size() > rxBytes.size()) void'(expQ.pop_back());
        compareStream("prerst");
        fifoQ.delete();
        popPending = 0;
        modelSeq = 8'h00;
        fifo_empty = 1'b1;
        readyMode = 0;
        applyStimulus();
        applyStimulus();
        rst_a = 1'b0;
        for (int i = 0; i < 10; i++) applyStimulus();
        checkOutput("rst_no_done", 32'(doneCount), 32'(doneBefore));
        checkOutput("rst_idle_busy", 32'(frame_busy), 32'(0));

        // 257 frames with random backpressure: sequence wraps FF -> 00
        readyMode = 1;
        d0 = doneCount;
        addFrames(257);
        runUntilDone(d0 + 257, 257 * 60, "wrap_done");
        checkOutput("seq_first", 32'(byteAt(1)), 32'h000);
        checkOutput("seq_ff", 32'(byteAt(255 * FL + 1)), 32'h0FF);
        checkOutput("seq_wrap", 32'(byteAt(256 * FL + 1)), 32'h000);
        compareStream("wrap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fifo_frame_tx.md
# fifo_frame_tx

Downstream drain stage for the 16-bit acquisition sample FIFO. Pops samples one at a time through the FIFO read port and serialises them into byte frames on a valid/ready byte stream toward the UART transmitter. Each frame carries:
- a sync byte;
- an 8-bit frame sequence number;
- FRAME_SAMPLES samples, each sent MSB byte first;
- an optional 8-bit checksum.

## Interface
- DATA_WIDTH, 16, FIFO word width; only 16 is supported.
- FRAME_SAMPLES, 8, samples per frame; range 1..255.
- SYNC_BYTE, 8'hA5, first byte of every frame.
- clk  in  1  clock; all logic is on the rising edge.
- rst_a  in  1  reset, asynchronous, active-high; clock clk.
- fifo_empty  in  1  FIFO empty flag.
- fifo_dout  in  16  FIFO read data.
- fifo_rd_en  out  1  FIFO read strobe; one pulse pops one word.
- tx_data  out  8  byte to the transmitter.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  transmitter accepts the byte this cycle.
- frame_busy  out  1  high from sync byte issue until the last byte of the frame is accepted.
- frame_done  out  1  one-cycle pulse in the cycle after the last byte of a frame is accepted.

## Operation
- FSM states: IDLE, SYNC, SEQ, RD_REQ, RD_WAIT, DATA_HI, DATA_LO, CSUM.
- IDLE: when fifo_empty=0, go to SYNC.
  - The frame is committed at this point; it does not wait for FRAME_SAMPLES words to be present.
- SYNC: present SYNC_BYTE; go to SEQ on acceptance.
- SEQ: present seq_cnt; go to RD_REQ on acceptance.
- RD_REQ: when fifo_empty=0, drive fifo_rd_en=1 for exactly one cycle and go to RD_WAIT.
  - If the FIFO is empty, stall in RD_REQ with fifo_rd_en=0.
  - A partial frame waits indefinitely for data.
- RD_WAIT: capture fifo_dout into the sample register; go to DATA_HI.
- DATA_HI: present sample[15:8]; go to DATA_LO on acceptance.
- DATA_LO: present sample[7:0]. On acceptance:
  - increment the sample counter;
  - if the counter is below FRAME_SAMPLES, go to RD_REQ;
  - otherwise go to CSUM if enabled, else end the frame.
- CSUM: present the checksum; end the frame on acceptance.
- End of frame:
  - seq_cnt increments, wrapping 8'hFF -> 8'h00;
  - sample counter clears;
  - frame_done pulses;
  - FSM returns to IDLE.
- Handshake rules:
  - A byte is accepted when tx_valid=1 and tx_ready=1 on the same edge.
  - While tx_valid=1 and tx_ready=0, tx_data is held stable.
  - tx_valid never drops before acceptance.
- fifo_rd_en is never asserted while fifo_empty=1. At most one read is outstanding.
- Reset values: fifo_rd_en=0, tx_valid=0, tx_data=8'h00, frame_busy=0, frame_done=0, seq_cnt=0, sample counter=0, checksum=0, state IDLE.
- Reset mid-frame: the partial frame is abandoned and all outputs take their reset values asynchronously. After reset the next frame starts with seq 0.

## Timing
- IDLE to the first tx_valid (SYNC): 1 cycle after fifo_empty=0 is sampled.
- fifo_rd_en high in cycle t; fifo_dout is valid and captured in cycle t+1; DATA_HI byte is valid from t+2.
- Each state presenting a byte holds for a minimum of 1 cycle; the next byte is valid the cycle after acceptance.
- With tx_ready tied high and the FIFO never empty:
  - frame length is 2 + 4×FRAME_SAMPLES (+1 with checksum) cycles;
  - plus 1 IDLE cycle between frames.
- frame_done pulses exactly once per completed frame and never after reset abandonment.

## Configuration
- FRAME_CHECKSUM_EN defined:
  - the CSUM state exists;
  - checksum = (seq byte + all data bytes) mod 256; the sync byte is excluded;
  - the accumulator clears at SYNC acceptance.
- FRAME_CHECKSUM_EN undefined:
  - no CSUM state and no accumulator logic;
  - the frame ends on acceptance of the last DATA_LO byte.

## Test plan
- FRAME_SAMPLES=2, checksum on, FIFO holds 0x1234 and 0xABCD, tx_ready=1 -> bytes A5 00 12 34 AB CD BE; single frame_done pulse; exactly 2 fifo_rd_en pulses.
- Same stimulus, checksum off -> bytes A5 00 12 34 AB CD; frame_done pulses 1 cycle after the CD byte is accepted.
- tx_ready toggled 1-0-0-1 pseudo-randomly over 4 frames -> byte sequence identical to the tx_ready=1 run; tx_data never changes while tx_valid=1 and tx_ready=0.
- FIFO goes empty after the first sample of a 2-sample frame for 20 cycles -> FSM stalls in RD_REQ; fifo_rd_en stays 0; the frame completes correctly once a word arrives.
- Run 257 frames -> seq bytes 00..FF then 00; checksum correct on every frame.
- Assert rst_a during the DATA_LO of frame 3 -> tx_valid=0 and frame_busy=0 immediately; no frame_done; the next frame sends seq 00.
